// File: rtl/t05_bus_arbiter.sv
// t05_bus_arbiter: two-port round-robin arbiter feeding a single bus manager
//   clk, nRST                  clock, asynchronous active-low reset
//   m0_*/m1_* (in)             read/write strobes, address, write data, byte select
//   m0_*/m1_* (out)            ack/err completion pulses and read data
//   busy_o, cpu_dat_o (in)     bus manager busy flag and read data
//   read_i, write_i, adr_i,
//   cpu_dat_i, sel_i (out)     registered bus request towards the manager
//   gnt (out)                  port owning the current or last transaction
module t05_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_wdat,
   input  logic [3:0]  m0_sel,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdat,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_wdat,
   input  logic [3:0]  m1_sel,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdat,
   input  logic        busy_o,
   input  logic [31:0] cpu_dat_o,
   output logic        read_i,
   output logic        write_i,
   output logic [31:0] adr_i,
   output logic [31:0] cpu_dat_i,
   output logic [3:0]  sel_i,
   output logic        gnt
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t      r_state, w_state;
   logic [7:0]  r_cnt, w_cnt;
   logic        r_last, w_last, r_gnt, w_gnt;
   logic        r_rd, w_rd, r_wr, w_wr, r_err, w_err, w_clr;
   logic [31:0] r_adr, w_adr, r_wdat, w_wdat, r_data, w_data;
   logic [3:0]  r_sel, w_sel;
   logic        w_req0, w_req1, w_pick, w_prd, w_pwr, w_timeout;
   assign w_req0    = m0_read | m0_write;
   assign w_req1    = m1_read | m1_write;
   // on contention the port that did not own the last transaction wins
   assign w_pick    = (w_req0 & w_req1) ? ~r_last : w_req1;
   assign w_prd     = w_pick ? m1_read : m0_read;
   assign w_pwr     = w_pick ? m1_write : m0_write;
   // the count including this busy cycle would reach the limit
   assign w_timeout = ({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT);
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_last  = r_last;
      w_gnt   = r_gnt;
      w_rd    = r_rd;
      w_wr    = r_wr;
      w_adr   = r_adr;
      w_wdat  = r_wdat;
      w_sel   = r_sel;
      w_data  = r_data;
      w_err   = 1'b0;
      w_clr   = 1'b0;
      case (r_state)
         IDLE: if (w_req0 | w_req1) begin
            w_state = ISSUE;
            w_gnt   = w_pick;
            w_last  = w_pick;
            w_rd    = w_prd;
            w_wr    = w_pwr & ~w_prd;
            w_adr   = w_pick ? m1_adr : m0_adr;
            w_wdat  = w_prd ? '0 : (w_pick ? m1_wdat : m0_wdat);
            w_sel   = w_pick ? m1_sel : m0_sel;
         end
         ISSUE: begin
            w_state = WAIT;
            w_cnt   = '0;
         end
         WAIT: if (!busy_o) begin
            w_state = RESP;
            w_data  = r_rd ? cpu_dat_o : '0;
            w_clr   = 1'b1;
         end else if (w_timeout) begin
            w_state = IDLE;
            w_err   = 1'b1;
            w_clr   = 1'b1;
         end else begin
            w_cnt   = r_cnt + 8'd1;
         end
         default: w_state = IDLE;
      endcase
      if (w_clr) begin
         w_rd   = 1'b0;
         w_wr   = 1'b0;
         w_adr  = '0;
         w_wdat = '0;
         w_sel  = '0;
      end
   end
   always_ff @(posedge clk or negedge nRST)
      if (!nRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_gnt   <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_adr   <= '0;
         r_wdat  <= '0;
         r_sel   <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_last  <= w_last;
         r_gnt   <= w_gnt;
         r_rd    <= w_rd;
         r_wr    <= w_wr;
         r_adr   <= w_adr;
         r_wdat  <= w_wdat;
         r_sel   <= w_sel;
         r_data  <= w_data;
         r_err   <= w_err;
      end
   // completion pulses and read data only ever reach the granted port
   assign m0_ack    = (r_state == RESP) & ~r_gnt;
   assign m1_ack    = (r_state == RESP) & r_gnt;
   assign m0_err    = r_err & ~r_gnt;
   assign m1_err    = r_err & r_gnt;
   assign m0_rdat   = m0_ack ? r_data : '0;
   assign m1_rdat   = m1_ack ? r_data : '0;
   assign read_i    = r_rd;
   assign write_i   = r_wr;
   assign adr_i     = r_adr;
   assign cpu_dat_i = r_wdat;
   assign sel_i     = r_sel;
   assign gnt       = r_gnt;
endmodule

// File: tb/tb_t05_bus_arbiter.sv
// tb_t05_bus_arbiter: table vectors, directed corner sequences and a randomized timeline model
module tb_t05_bus_arbiter;
   localparam int TO = 4;
   typedef logic [138:0] vec_t;
   typedef struct {
      logic        p;
      logic        rd, wr;
      logic [31:0] adr, wdat;
      logic [3:0]  sel;
      int          nbusy;
      logic [31:0] dat;
      logic        e_rd, e_wr;
      logic [31:0] e_wdat;
      int          e_strb, e_lat;
      logic [31:0] e_rdat;
      logic        e_err;
   } vec_s;
   logic        clk = 1'b0, nRST = 1'b0;
   logic        t_rd [2], t_wr [2];
   logic [31:0] t_adr [2], t_wdat [2];
   logic [3:0]  t_sel [2];
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdat, m1_rdat;
   logic        busy_o;
   logic [31:0] cpu_dat_o;
   logic        read_i, write_i, gnt;
   logic [31:0] adr_i, cpu_dat_i;
   logic [3:0]  sel_i;
   vec_t        dut_v;
   logic [1:0]  ack_v, err_v;
   logic [31:0] rdat_v [2];
   int          n_pass = 0, n_tot = 0;
   vec_s        tbl [6];
   assign m0_read = t_rd[0];
   assign m0_write = t_wr[0];
   assign m0_adr = t_adr[0];
   assign m0_wdat = t_wdat[0];
   assign m0_sel = t_sel[0];
   assign m1_read = t_rd[1];
   assign m1_write = t_wr[1];
   assign m1_adr = t_adr[1];
   assign m1_wdat = t_wdat[1];
   assign m1_sel = t_sel[1];
   assign dut_v = {read_i, write_i, adr_i, cpu_dat_i, sel_i, gnt, m0_ack, m0_err, m0_rdat, m1_ack, m1_err, m1_rdat};
   assign ack_v = {m1_ack, m0_ack};
   assign err_v = {m1_err, m0_err};
   assign rdat_v[0] = m0_rdat;
   assign rdat_v[1] = m1_rdat;
   t05_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .nRST(nRST),
      .m0_read(m0_read), .m0_write(m0_write), .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_sel(m0_sel),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdat(m0_rdat),
      .m1_read(m1_read), .m1_write(m1_write), .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_sel(m1_sel),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdat(m1_rdat),
      .busy_o(busy_o), .cpu_dat_o(cpu_dat_o),
      .read_i(read_i), .write_i(write_i), .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .sel_i(sel_i), .gnt(gnt)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
   task automatic chk(input string name, input vec_t act, input vec_t exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic clear_inputs();
      for (int p = 0; p < 2; p++) begin
         t_rd[p] = 1'b0;
         t_wr[p] = 1'b0;
         t_adr[p] = '0;
         t_wdat[p] = '0;
         t_sel[p] = '0;
      end
      busy_o = 1'b0;
      cpu_dat_o = '0;
   endtask
   task automatic do_reset();
      nRST = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 chk("reset", dut_v, '0);
      nRST = 1'b1;
   endtask
   task automatic rand_fields(input int p);
      t_adr[p] = $urandom;
      t_wdat[p] = $urandom;
      t_sel[p] = 4'($urandom);
   endtask
   task automatic run_vec(input vec_s v, input string tag);
      int strb = 0, lat = 0;
      logic [31:0] rdat = '0;
      logic [1:0] resp = '0;
      logic quiet = 1'b1;
      vec_t bus = '0;
      cpu_dat_o = v.dat;
      busy_o = 1'b0;
      t_rd[v.p] = v.rd;
      t_wr[v.p] = v.wr;
      t_adr[v.p] = v.adr;
      t_wdat[v.p] = v.wdat;
      t_sel[v.p] = v.sel;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(posedge clk);
         #1;
         busy_o = (n <= 1 + v.nbusy);
         if (n == 1) bus = {read_i, write_i, adr_i, cpu_dat_i, sel_i, gnt};
         strb += int'(read_i | write_i);
         if (ack_v[v.p] | err_v[v.p]) begin
            lat = n;
            rdat = rdat_v[v.p];
            resp = {ack_v[v.p], err_v[v.p]};
            t_rd[v.p] = 1'b0;
            t_wr[v.p] = 1'b0;
         end
         if (ack_v[!v.p] | err_v[!v.p] | (rdat_v[!v.p] != 0)) quiet = 1'b0;
      end
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " bus"}, bus, {v.e_rd, v.e_wr, v.adr, v.e_wdat, v.sel, v.p});
      chk({tag, " strobe_cycles"}, strb, v.e_strb);
      chk({tag, " latency"}, lat, v.e_lat);
      chk({tag, " rdat"}, rdat, v.e_rdat);
      chk({tag, " ack_err"}, resp, {!v.e_err, v.e_err});
      chk({tag, " other_port_quiet"}, quiet, 1);
   endtask
   initial begin
      logic [3:0] seq;
      int na, g, k, free_at, d;
      logic ok, last, egnt, mp, mrd, mwr, to, strb, ea, ee, r0, r1, pk;
      logic [31:0] madr, mwdat, mdat;
      logic [3:0] msel;
      logic [1:0] rw;
      //         p  rd wr adr           wdat          sel   nb  dat           e_rd e_wr e_wdat    strb lat e_rdat        err
      tbl[0] = '{1'b0, 1, 0, 32'h0000_0040, 32'h0,        4'hF, 2,  32'hDEAD_BEEF, 1, 0, 32'h0,        4, 5, 32'hDEAD_BEEF, 0};
      tbl[1] = '{1'b1, 0, 1, 32'h0000_2000, 32'h1234_5678, 4'hF, 0,  32'hFFFF_FFFF, 0, 1, 32'h1234_5678, 2, 3, 32'h0,        0};
      tbl[2] = '{1'b0, 1, 1, 32'h0000_0100, 32'hAAAA_5555, 4'h3, 1,  32'h0BAD_F00D, 1, 0, 32'h0,        3, 4, 32'h0BAD_F00D, 0};
      tbl[3] = '{1'b0, 1, 0, 32'h0000_0044, 32'h0,        4'h1, 99, 32'h1212_1212, 1, 0, 32'h0,        5, 6, 32'h0,        1};
      tbl[4] = '{1'b1, 1, 0, 32'h0000_3000, 32'h0,        4'hC, 3,  32'hCAFE_F00D, 1, 0, 32'h0,        5, 6, 32'hCAFE_F00D, 0};
      tbl[5] = '{1'b1, 0, 1, 32'h0000_3004, 32'h5A5A_5A5A, 4'hF, 7,  32'h7777_7777, 0, 1, 32'h5A5A_5A5A, 5, 6, 32'h0,        1};
      do_reset();
      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
      // both ports hold requests: grants must alternate starting with port 0
      do_reset();
      t_rd[0] = 1'b1;
      t_adr[0] = 32'h10;
      t_rd[1] = 1'b1;
      t_adr[1] = 32'h20;
      seq = '0;
      na = 0;
      for (int c = 0; c < 18; c++) begin
         if (m0_ack | m1_ack) begin
            seq = {seq[2:0], m1_ack};
            na++;
         end
         @(posedge clk);
         #1;
      end
      clear_inputs();
      repeat (4) @(posedge clk);
      #1;
      chk("rr ack_count", na, 4);
      chk("rr ack_order", seq, 4'b0101);
      // reset in the middle of a waiting read aborts it and restores port-0 priority
      run_vec(tbl[0], "pre_rst");
      t_rd[0] = 1'b1;
      t_adr[0] = 32'h80;
      t_sel[0] = 4'hF;
      busy_o = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("rst mid_wait_strobe", read_i, 1);
      #1 nRST = 1'b0;
      clear_inputs();
      #1 chk("rst async_outputs", dut_v, '0);
      @(posedge clk);
      #1 nRST = 1'b1;
      ok = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (m0_ack | m0_err | m1_ack | m1_err) ok = 1'b0;
      end
      chk("rst no_resp_after", ok, 1);
      t_rd[0] = 1'b1;
      t_rd[1] = 1'b1;
      @(posedge clk);
      #1 chk("rst first_contention", {read_i, gnt}, 2'b10);
      // randomized traffic against a transaction timeline model
      do_reset();
      g = -100;
      k = 0;
      free_at = 0;
      last = 1'b1;
      egnt = 1'b0;
      mp = 1'b0;
      mrd = 1'b0;
      mwr = 1'b0;
      madr = '0;
      mwdat = '0;
      msel = '0;
      mdat = '0;
      for (int c = 0; c < 1500; c++) begin
         d = c - g;
         to = (k >= TO);
         strb = to ? (d >= 1 && d <= TO + 1) : (d >= 1 && d <= k + 2);
         ea = !to && d == k + 3;
         ee = to && d == TO + 2;
         if (d == 1) egnt = mp;
         chk($sformatf("rand cycle%0d", c), dut_v,
             {strb & mrd, strb & mwr, strb ? madr : 32'h0, strb ? mwdat : 32'h0, strb ? msel : 4'h0, egnt,
              ea & !mp, ee & !mp, (ea & !mp) ? mdat : 32'h0, ea & mp, ee & mp, (ea & mp) ? mdat : 32'h0});
         for (int p = 0; p < 2; p++) begin
            if ((ea || ee) && int'(mp) == p) begin
               t_rd[p] = 1'b0;
               t_wr[p] = 1'b0;
            end else if (!t_rd[p] && !t_wr[p]) begin
               if ($urandom % 3 == 0) begin
                  rw = 2'($urandom_range(1, 3));
                  t_rd[p] = rw[0];
                  t_wr[p] = rw[1];
                  rand_fields(p);
               end
            end else begin
               if ($urandom % 4 == 0) rand_fields(p);
               if ($urandom % 16 == 0) begin
                  t_rd[p] = 1'b0;
                  t_wr[p] = 1'b0;
               end
            end
         end
         busy_o = (d >= 2 && d <= (to ? TO : k) + 1) ? 1'b1 : (!to && d == k + 2) ? 1'b0 : 1'($urandom);
         cpu_dat_o = $urandom;
         if (!to && d == k + 2) mdat = mrd ? cpu_dat_o : 32'h0;
         r0 = t_rd[0] | t_wr[0];
         r1 = t_rd[1] | t_wr[1];
         if (c >= free_at && (r0 || r1)) begin
            pk = (r0 && r1) ? !last : r1;
            g = c;
            k = $urandom_range(0, 5);
            mp = pk;
            last = pk;
            mrd = t_rd[pk];
            mwr = !t_rd[pk] && t_wr[pk];
            madr = t_adr[pk];
            mwdat = t_rd[pk] ? 32'h0 : t_wdat[pk];
            msel = t_sel[pk];
            free_at = (k >= TO) ? g + TO + 2 : g + k + 4;
         end
         @(posedge clk);
         #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/t05_bus_arbiter.md
T05_BUS_ARBITER -- requirements
Module: t05_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a transaction is aborted (range 1..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 m0_read, m0_write  input  1 each  port-0 read / write request, held until m0_ack or m0_err.
REQ-005 m0_adr, m0_wdat  input  32 each  port-0 address / write data.
REQ-006 m0_sel  input  4  port-0 byte select.
REQ-007 m0_ack, m0_err  output  1 each  port-0 one-cycle completion / timeout pulse.
REQ-008 m0_rdat  output  32  port-0 read data, valid in the m0_ack cycle.
REQ-009 Port 1 SHALL have the identical signal set, prefixed m1_.
REQ-010 busy_o  input  1  bus manager busy.
REQ-011 cpu_dat_o  input  32  bus manager read data.
REQ-012 read_i, write_i  output  1 each  bus strobes.
REQ-013 adr_i, cpu_dat_i  output  32 each  bus address / write data.
REQ-014 sel_i  output  4  bus byte select.
REQ-015 gnt  output  1  index of the port owning the current or last transaction.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 A port SHALL be considered requesting when its read or write input is high; if both are high, the transaction SHALL be a read.
REQ-018 In IDLE with exactly one port requesting, that port SHALL be granted.
REQ-019 In IDLE with both ports requesting, the port other than last_gnt SHALL be granted (round-robin).
REQ-020 On grant, the block SHALL register that port's strobe, address, write data (0 on reads) and sel into the bus outputs, set gnt and last_gnt, and enter ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle with strobes asserted, ignoring busy_o, then enter WAIT.
REQ-022 In WAIT, strobes and bus outputs SHALL be held and an 8-bit counter, cleared on entering WAIT, SHALL increment each cycle busy_o is high.
REQ-023 In WAIT, on the first cycle busy_o is low, the block SHALL capture cpu_dat_o (reads only), clear all bus outputs to 0 and enter RESP.
REQ-024 In RESP, the block SHALL pulse the granted port's ack for one cycle, drive its rdat with the captured data (0 for writes), and return to IDLE.
REQ-025 If the WAIT counter reaches TIMEOUT with busy_o still high, the block SHALL clear bus outputs, pulse the granted port's err for one cycle (ack stays low), and return to IDLE.
REQ-026 Inputs of a granted port SHALL be ignored after the grant cycle; request withdrawal mid-transaction SHALL NOT abort the transaction.
REQ-027 A new grant SHALL NOT occur before the IDLE cycle following RESP or timeout, giving a minimum of 4 cycles per transaction.
REQ-028 Non-granted ports SHALL see ack=0, err=0, rdat=0 at all times.
REQ-029 The latency from a request sampled in IDLE to ack SHALL be 3 cycles plus the number of WAIT cycles with busy_o high.

Reset
REQ-030 On nRST low, all outputs SHALL go to 0 asynchronously, the state SHALL go to IDLE, the counter to 0, and last_gnt to 1, so port 0 wins the first contention.
REQ-031 Reset asserted mid-transaction SHALL abort it with no ack or err pulse after release.

Verification
REQ-032 Single port-0 read at 0x0000_0040 with sel=4'hF, busy_o high for 2 WAIT cycles, cpu_dat_o=0xDEAD_BEEF -> read_i high 4 cycles, m0_ack pulse with m0_rdat=0xDEAD_BEEF.
REQ-033 Both ports requesting continuously after reset -> grants alternate 0,1,0,1, and no port is granted twice in a row.
REQ-034 Port-1 write 0x1234_5678 to 0x0000_2000, busy_o low in the first WAIT cycle -> write_i high 2 cycles, cpu_dat_i=0x1234_5678, m1_ack 3 cycles after the request, m1_rdat=0.
REQ-035 With TIMEOUT=4, busy_o stuck high -> after 4 WAIT cycles, m0_err pulses, strobes drop, m0_ack stays low, and the FSM returns to IDLE.
REQ-036 nRST pulsed during WAIT -> all outputs 0 immediately, no ack after release, and the next contention is granted to port 0.
REQ-037 m0_read and m0_write both high -> read_i=1, write_i=0, cpu_dat_i=0.
